// File: rtl/dbus_bridge_if.sv
// Core-side (ram_*) and bus-side (bus_*) signal bundle for dbus_bridge.
// The bridge takes the slave view; the core/bus environment takes the master view.
interface dbus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              ram_ce;
  logic              ram_we;
  logic [SEL_W-1:0]  ram_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              stallreq;

  logic              bus_req;
  logic              bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, bus_ack, bus_rdata,
    input  ram_rdata, stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, bus_ack, bus_rdata,
    output ram_rdata, stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/dbus_bridge.sv
// MEM-stage to req/ack data bus bridge; stalls the pipeline until the bus acknowledges.
// Optional wait-state timeout abort is enabled by defining DBUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for ram_ce; stall follows ram_ce combinationally
// REQ   | bus_req asserted with latched fields; stalled until ack (or timeout)
// DONE  | one unstalled cycle so the pipeline advances; ram_ce ignored
module dbus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255
) (
  input logic         clk,
  input logic         rst,
  dbus_bridge_if.slave dbus
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              latch, capture, abort, to_hit;
  logic              we_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Ack beats a simultaneous terminal count.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (dbus.ram_ce) begin
        latch     = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (dbus.bus_ack) begin
        capture   = 1'b1;
        state_nxt = DONE;
      end else if (to_hit) begin
        abort     = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (latch) begin
        we_q    <= dbus.ram_we;
        sel_q   <= dbus.ram_sel;
        addr_q  <= dbus.ram_addr;
        wdata_q <= dbus.ram_wdata;
      end
      if (capture && !we_q) rdata_q <= dbus.bus_rdata;
      else if (abort)       rdata_q <= '0;
    end
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (latch)                             cnt <= '0;
      else if (state == REQ && !dbus.bus_ack) cnt <= cnt + CNT_W'(1);
    end
  end

  // The REQ cycle that would take the count to TO_CYC is the last one.
  assign to_hit       = (cnt == CNT_W'(TO_CYC - 1));
  assign dbus.bus_err = err_q;
`else
  logic unused_to_cyc;

  // Keeps TO_CYC referenced when the timeout logic is compiled out.
  assign unused_to_cyc = (TO_CYC == 0);
  assign to_hit        = 1'b0;
  assign dbus.bus_err  = 1'b0;
`endif

  assign dbus.bus_req   = (state == REQ);
  assign dbus.stallreq  = (state == REQ) || (state == IDLE && dbus.ram_ce);
  assign dbus.bus_we    = we_q;
  assign dbus.bus_sel   = sel_q;
  assign dbus.bus_addr  = addr_q;
  assign dbus.bus_wdata = wdata_q;
  assign dbus.ram_rdata = rdata_q;
endmodule
